// File: rtl/wb_write_queue_if.sv
// Writeback queue bus: producer-side results, register-file write port,
// queue status and forwarding lookup, bundled for the wb_write_queue.
interface wb_write_queue_if #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8,
    parameter int DEPTH  = 4
);
    localparam int AW = $clog2(N_REGS);
    localparam int CW = $clog2(DEPTH + 1);

    // MEM / ALU result paths
    logic             mem_valid;
    logic [AW-1:0]    mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             alu_valid;
    logic [AW-1:0]    alu_addr;
    logic [WIDTH-1:0] alu_data;

    // Queue status
    logic             stall;
    logic [CW-1:0]    count;
    logic             overflow;

    // Register-file write port
    logic             RegWrite;
    logic [AW-1:0]    write_address;
    logic [WIDTH-1:0] write_data;

    // Forwarding lookup
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic             fwd_hit1;
    logic             fwd_hit2;
    logic [WIDTH-1:0] fwd_data1;
    logic [WIDTH-1:0] fwd_data2;

    // Queue side
    modport slave (
        input  mem_valid, mem_addr, mem_data,
        input  alu_valid, alu_addr, alu_data,
        input  rd_addr1, rd_addr2,
        output stall, count, overflow,
        output RegWrite, write_address, write_data,
        output fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );

    // Pipeline / register-file side
    modport master (
        output mem_valid, mem_addr, mem_data,
        output alu_valid, alu_addr, alu_data,
        output rd_addr1, rd_addr2,
        input  stall, count, overflow,
        input  RegWrite, write_address, write_data,
        input  fwd_hit1, fwd_hit2, fwd_data1, fwd_data2
    );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: accepts up to two writeback results per cycle (MEM older
// than ALU), buffers them in an in-order circular queue and issues one
// register-file write per cycle through a registered output stage. When the
// queue is empty the oldest incoming result bypasses straight into the
// output register.
// Optional feature macro: WB_FWD_EN builds the pending-write lookup
// (fwd_hit/fwd_data); without it those outputs are tied to zero.
module wb_write_queue #(
    parameter int WIDTH  = 16,
    parameter int N_REGS = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    wb_write_queue_if.slave   bus
);
    localparam int AW = $clog2(N_REGS);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = CW + 1;

    localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE   = PW'(1'b1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] CNT_STALL = CW'(DEPTH - 2);
    localparam logic [FW-1:0] FREE_ZERO = {FW{1'b0}};
    localparam logic [FW-1:0] FREE_ONE  = FW'(1'b1);
    localparam logic [FW-1:0] FREE_TWO  = FW'(2'd2);
    localparam logic [FW-1:0] FREE_MAX  = FW'(DEPTH);

    // Queue storage and pointers
    logic [AW-1:0]    addr_q_r [DEPTH];
    logic [WIDTH-1:0] data_q_r [DEPTH];
    logic [PW-1:0]    head_r;
    logic [PW-1:0]    tail_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;

    // Output stage
    logic             reg_write_r;
    logic [AW-1:0]    wr_addr_r;
    logic [WIDTH-1:0] wr_data_r;

    // Per-cycle decisions
    logic             pop_s;
    logic             out_load_s;
    logic [AW-1:0]    out_addr_s;
    logic [WIDTH-1:0] out_data_s;
    logic             c0_valid_s;
    logic [AW-1:0]    c0_addr_s;
    logic [WIDTH-1:0] c0_data_s;
    logic             c1_valid_s;
    logic [AW-1:0]    c1_addr_s;
    logic [WIDTH-1:0] c1_data_s;
    logic [FW-1:0]    free_s;
    logic             acc0_s;
    logic             acc1_s;
    logic             drop_s;
    logic [PW-1:0]    tail_p1_s;
    logic [PW-1:0]    tail_nxt_s;
    logic [CW-1:0]    count_nxt_s;

    assign pop_s = (count_r != CNT_ZERO);

    // Pick what the output register loads and which results become append candidates (oldest first)
    always_comb begin
        out_load_s = 1'b0;
        out_addr_s = wr_addr_r;
        out_data_s = wr_data_r;
        c0_valid_s = 1'b0;
        c0_addr_s  = {AW{1'b0}};
        c0_data_s  = {WIDTH{1'b0}};
        c1_valid_s = 1'b0;
        c1_addr_s  = {AW{1'b0}};
        c1_data_s  = {WIDTH{1'b0}};
        if (pop_s) begin
            // Queue head is older than anything arriving now
            out_load_s = 1'b1;
            out_addr_s = addr_q_r[head_r];
            out_data_s = data_q_r[head_r];
            if (bus.mem_valid) begin
                c0_valid_s = 1'b1;
                c0_addr_s  = bus.mem_addr;
                c0_data_s  = bus.mem_data;
                if (bus.alu_valid) begin
                    c1_valid_s = 1'b1;
                    c1_addr_s  = bus.alu_addr;
                    c1_data_s  = bus.alu_data;
                end else begin
                    c1_valid_s = 1'b0;
                end
            end else if (bus.alu_valid) begin
                c0_valid_s = 1'b1;
                c0_addr_s  = bus.alu_addr;
                c0_data_s  = bus.alu_data;
            end else begin
                c0_valid_s = 1'b0;
            end
        end else if (bus.mem_valid) begin
            // Empty queue: MEM bypasses, ALU (if any) is queued behind it
            out_load_s = 1'b1;
            out_addr_s = bus.mem_addr;
            out_data_s = bus.mem_data;
            if (bus.alu_valid) begin
                c0_valid_s = 1'b1;
                c0_addr_s  = bus.alu_addr;
                c0_data_s  = bus.alu_data;
            end else begin
                c0_valid_s = 1'b0;
            end
        end else if (bus.alu_valid) begin
            out_load_s = 1'b1;
            out_addr_s = bus.alu_addr;
            out_data_s = bus.alu_data;
        end else begin
            out_load_s = 1'b0;
        end
    end

    // Free slots count the entry popped on this same edge
    assign free_s      = FREE_MAX - {1'b0, count_r} + (pop_s ? FREE_ONE : FREE_ZERO);
    assign acc0_s      = c0_valid_s && (free_s >= FREE_ONE);
    assign acc1_s      = c1_valid_s && (free_s >= FREE_TWO);
    assign drop_s      = (c0_valid_s && !acc0_s) || (c1_valid_s && !acc1_s);
    assign tail_p1_s   = tail_r + PTR_ONE;
    assign tail_nxt_s  = tail_r + (acc0_s ? PTR_ONE : PTR_ZERO) + (acc1_s ? PTR_ONE : PTR_ZERO);
    assign count_nxt_s = count_r + (acc0_s ? CNT_ONE : CNT_ZERO) + (acc1_s ? CNT_ONE : CNT_ZERO)
                         - (pop_s ? CNT_ONE : CNT_ZERO);

    // Queue state, sticky overflow and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q_r[i] <= {AW{1'b0}};
                data_q_r[i] <= {WIDTH{1'b0}};
            end
            head_r      <= PTR_ZERO;
            tail_r      <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            reg_write_r <= 1'b0;
            wr_addr_r   <= {AW{1'b0}};
            wr_data_r   <= {WIDTH{1'b0}};
        end else begin
            reg_write_r <= out_load_s;
            wr_addr_r   <= out_addr_s;
            wr_data_r   <= out_data_s;
            if (acc0_s) begin
                addr_q_r[tail_r] <= c0_addr_s;
                data_q_r[tail_r] <= c0_data_s;
            end
            if (acc1_s) begin
                addr_q_r[tail_p1_s] <= c1_addr_s;
                data_q_r[tail_p1_s] <= c1_data_s;
            end
            head_r  <= pop_s ? (head_r + PTR_ONE) : head_r;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign bus.stall         = (count_r > CNT_STALL);
    assign bus.count         = count_r;
    assign bus.overflow      = overflow_r;
    assign bus.RegWrite      = reg_write_r;
    assign bus.write_address = wr_addr_r;
    assign bus.write_data    = wr_data_r;

`ifdef WB_FWD_EN
    logic             fwd_hit1_s;
    logic             fwd_hit2_s;
    logic [WIDTH-1:0] fwd_data1_s;
    logic [WIDTH-1:0] fwd_data2_s;
    logic [PW-1:0]    fwd_idx_s;

    // Youngest pending write wins: output reg first, then queue entries oldest to youngest overriding
    always_comb begin
        fwd_hit1_s  = 1'b0;
        fwd_hit2_s  = 1'b0;
        fwd_data1_s = {WIDTH{1'b0}};
        fwd_data2_s = {WIDTH{1'b0}};
        fwd_idx_s   = head_r;
        if (reg_write_r && (wr_addr_r == bus.rd_addr1)) begin
            fwd_hit1_s  = 1'b1;
            fwd_data1_s = wr_data_r;
        end else begin
            fwd_hit1_s  = 1'b0;
        end
        if (reg_write_r && (wr_addr_r == bus.rd_addr2)) begin
            fwd_hit2_s  = 1'b1;
            fwd_data2_s = wr_data_r;
        end else begin
            fwd_hit2_s  = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx_s = head_r + PW'(i);
            if ((CW'(i) < count_r) && (addr_q_r[fwd_idx_s] == bus.rd_addr1)) begin
                fwd_hit1_s  = 1'b1;
                fwd_data1_s = data_q_r[fwd_idx_s];
            end else begin
                fwd_hit1_s  = fwd_hit1_s;
            end
            if ((CW'(i) < count_r) && (addr_q_r[fwd_idx_s] == bus.rd_addr2)) begin
                fwd_hit2_s  = 1'b1;
                fwd_data2_s = data_q_r[fwd_idx_s];
            end else begin
                fwd_hit2_s  = fwd_hit2_s;
            end
        end
    end

    assign bus.fwd_hit1  = fwd_hit1_s;
    assign bus.fwd_hit2  = fwd_hit2_s;
    assign bus.fwd_data1 = fwd_data1_s;
    assign bus.fwd_data2 = fwd_data2_s;
`else
    assign bus.fwd_hit1  = 1'b0;
    assign bus.fwd_hit2  = 1'b0;
    assign bus.fwd_data1 = {WIDTH{1'b0}};
    assign bus.fwd_data2 = {WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed testbench for wb_write_queue: reset, single write latency,
// dual-issue ordering, stall behaviour, overflow drop, forwarding lookup
// and asynchronous reset in the middle of traffic.
module tb_wb_write_queue;
    localparam int WIDTH  = 16;
    localparam int N_REGS = 8;
    localparam int DEPTH  = 4;
    localparam int AW     = 3;

`ifdef WB_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic clk;
    logic rst;

    wb_write_queue_if #(.WIDTH(WIDTH), .N_REGS(N_REGS), .DEPTH(DEPTH)) bus ();

    wb_write_queue #(.WIDTH(WIDTH), .N_REGS(N_REGS), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp;
    int n_bad;
    logic [AW-1:0]    hold_addr;
    logic [WIDTH-1:0] hold_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (got timeout, need completion)");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input logic mv, input logic [AW-1:0] ma, input logic [WIDTH-1:0] md,
                          input logic av, input logic [AW-1:0] aa, input logic [WIDTH-1:0] ad);
        bus.mem_valid = mv;
        bus.mem_addr  = ma;
        bus.mem_data  = md;
        bus.alu_valid = av;
        bus.alu_addr  = aa;
        bus.alu_data  = ad;
    endtask

    task automatic idle();
        set_in(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    endtask

    // Advance one edge and check the write port and count; address/data hold when no write
    task automatic step(input string tag, input logic e_rw, input logic [AW-1:0] e_addr,
                        input logic [WIDTH-1:0] e_data, input int e_cnt);
        @(posedge clk);
        #1;
        if (e_rw) begin
            hold_addr = e_addr;
            hold_data = e_data;
        end
        check_val({tag, ".rw"},   32'(bus.RegWrite),      32'(e_rw));
        check_val({tag, ".addr"}, 32'(bus.write_address), 32'(hold_addr));
        check_val({tag, ".data"}, 32'(bus.write_data),    32'(hold_data));
        check_val({tag, ".cnt"},  32'(bus.count),         32'(e_cnt));
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        hold_addr = 3'd0;
        hold_data = 16'h0000;
        rst       = 1'b1;
        bus.rd_addr1 = 3'd0;
        bus.rd_addr2 = 3'd0;
        idle();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.rw",   32'(bus.RegWrite),      32'd0);
        check_val("rst.cnt",  32'(bus.count),         32'd0);
        check_val("rst.ovf",  32'(bus.overflow),      32'd0);
        check_val("rst.stl",  32'(bus.stall),         32'd0);
        check_val("rst.addr", 32'(bus.write_address), 32'd0);
        check_val("rst.data", 32'(bus.write_data),    32'd0);
        rst = 1'b0;
        step("idle", 1'b0, 3'd0, 16'h0000, 0);

        // Isolated ALU write: one cycle of RegWrite, then hold
        set_in(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234);
        step("t2a", 1'b1, 3'd3, 16'h1234, 0);
        idle();
        step("t2b", 1'b0, 3'd0, 16'h0000, 0);

        // MEM and ALU together: MEM first, ALU next cycle
        set_in(1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd5, 16'h5555);
        step("t3a", 1'b1, 3'd2, 16'hAAAA, 1);
        idle();
        step("t3b", 1'b1, 3'd5, 16'h5555, 0);
        step("t3c", 1'b0, 3'd0, 16'h0000, 0);

        // Three dual-issue cycles honoring stall, then drain
        check_val("t4.stl0", 32'(bus.stall), 32'd0);
        set_in(1'b1, 3'd1, 16'h0A01, 1'b1, 3'd2, 16'h0A02);
        step("t4a", 1'b1, 3'd1, 16'h0A01, 1);
        check_val("t4.stl1", 32'(bus.stall), 32'd0);
        set_in(1'b1, 3'd3, 16'h0A03, 1'b1, 3'd4, 16'h0A04);
        step("t4b", 1'b1, 3'd2, 16'h0A02, 2);
        check_val("t4.stl2", 32'(bus.stall), 32'd0);
        set_in(1'b1, 3'd5, 16'h0A05, 1'b1, 3'd6, 16'h0A06);
        step("t4c", 1'b1, 3'd3, 16'h0A03, 3);
        check_val("t4.stl3", 32'(bus.stall), 32'd1);
        idle();
        step("t4d", 1'b1, 3'd4, 16'h0A04, 2);
        check_val("t4.stl4", 32'(bus.stall), 32'd0);
        step("t4e", 1'b1, 3'd5, 16'h0A05, 1);
        step("t4f", 1'b1, 3'd6, 16'h0A06, 0);
        step("t4g", 1'b0, 3'd0, 16'h0000, 0);

        // Same destination twice: forwarding returns the younger value
        set_in(1'b1, 3'd4, 16'h0001, 1'b1, 3'd4, 16'h0002);
        step("t6a", 1'b1, 3'd4, 16'h0001, 1);
        idle();
        bus.rd_addr1 = 3'd4;
        bus.rd_addr2 = 3'd6;
        #1;
        check_val("t6.hit1q", 32'(bus.fwd_hit1),  32'(FWD));
        check_val("t6.dat1q", 32'(bus.fwd_data1), FWD ? 32'h0002 : 32'h0000);
        check_val("t6.hit2",  32'(bus.fwd_hit2),  32'd0);
        step("t6b", 1'b1, 3'd4, 16'h0002, 0);
        check_val("t6.hit1o", 32'(bus.fwd_hit1),  32'(FWD));
        check_val("t6.dat1o", 32'(bus.fwd_data1), FWD ? 32'h0002 : 32'h0000);
        step("t6c", 1'b0, 3'd0, 16'h0000, 0);
        check_val("t6.hit1n", 32'(bus.fwd_hit1),  32'd0);

        // Fill to 4 while ignoring stall; the fifth dual request keeps MEM, drops ALU
        set_in(1'b1, 3'd0, 16'h1000, 1'b1, 3'd4, 16'h1001);
        step("t5a", 1'b1, 3'd0, 16'h1000, 1);
        set_in(1'b1, 3'd1, 16'h1002, 1'b1, 3'd5, 16'h1003);
        step("t5b", 1'b1, 3'd4, 16'h1001, 2);
        set_in(1'b1, 3'd2, 16'h1004, 1'b1, 3'd6, 16'h1005);
        step("t5c", 1'b1, 3'd1, 16'h1002, 3);
        set_in(1'b1, 3'd3, 16'h1006, 1'b1, 3'd7, 16'h1007);
        step("t5d", 1'b1, 3'd5, 16'h1003, 4);
        check_val("t5.ovf0", 32'(bus.overflow), 32'd0);
        check_val("t5.stl",  32'(bus.stall),    32'd1);
        set_in(1'b1, 3'd4, 16'h1008, 1'b1, 3'd0, 16'h1009);
        step("t5e", 1'b1, 3'd2, 16'h1004, 4);
        check_val("t5.ovf1", 32'(bus.overflow), 32'd1);
        idle();
        step("t5f", 1'b1, 3'd6, 16'h1005, 3);
        step("t5g", 1'b1, 3'd3, 16'h1006, 2);
        step("t5h", 1'b1, 3'd7, 16'h1007, 1);
        step("t5i", 1'b1, 3'd4, 16'h1008, 0);
        step("t5j", 1'b0, 3'd0, 16'h0000, 0);
        check_val("t5.ovf2", 32'(bus.overflow), 32'd1);

        // Reset in the middle of traffic with three entries queued
        set_in(1'b1, 3'd1, 16'h2001, 1'b1, 3'd2, 16'h2002);
        step("t1a", 1'b1, 3'd1, 16'h2001, 1);
        set_in(1'b1, 3'd3, 16'h2003, 1'b1, 3'd4, 16'h2004);
        step("t1b", 1'b1, 3'd2, 16'h2002, 2);
        set_in(1'b1, 3'd5, 16'h2005, 1'b1, 3'd6, 16'h2006);
        step("t1c", 1'b1, 3'd3, 16'h2003, 3);
        idle();
        #2;
        rst = 1'b1;
        #1;
        check_val("t1.rw",  32'(bus.RegWrite), 32'd0);
        check_val("t1.cnt", 32'(bus.count),    32'd0);
        check_val("t1.ovf", 32'(bus.overflow), 32'd0);
        check_val("t1.stl", 32'(bus.stall),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold_addr = 3'd0;
        hold_data = 16'h0000;
        step("t1d", 1'b0, 3'd0, 16'h0000, 0);
        step("t1e", 1'b0, 3'd0, 16'h0000, 0);
        step("t1f", 1'b0, 3'd0, 16'h0000, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
